// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between icache and dcache miss paths
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              pick_d;

  // On a tie the port that did not win last time goes next.
  assign pick_d = d_req && (!i_req || (last_q == PORT_I));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = BUSY;
          owner_d = PORT_D;
          last_d  = PORT_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (dcnt_q != {CNT_W{1'b1}}) dcnt_d = dcnt_q + 1'b1;
        end else if (i_req) begin
          state_d = BUSY;
          owner_d = PORT_I;
          last_d  = PORT_I;
          addr_d  = i_addr;
          we_d    = 1'b0;
          if (icnt_q != {CNT_W{1'b1}}) icnt_d = icnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          buf_d   = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      last_q  <= PORT_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign i_ready   = (state_q == RESP) && (owner_q == PORT_I);
  assign d_ready   = (state_q == RESP) && (owner_q == PORT_D);
  assign i_rdata   = buf_q;
  assign d_rdata   = buf_q;
  assign i_grants  = icnt_q;
  assign d_grants  = dcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, d_req, d_we, mem_ack;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic              i_ready, d_ready, mem_req, mem_we, busy;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [CNT_W-1:0]  i_grants, d_grants;

  int vectors = 0;
  int errors  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .i_grants(i_grants), .d_grants(d_grants)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    reset = 0;
    step; step;
    reset = 1;
  endtask

  task automatic test_reset;
    i_req = 1; d_req = 1; d_we = 0; mem_ack = 0;
    i_addr = 32'h100; d_addr = 32'h2000; d_wdata = '0; mem_rdata = '0;
    reset = 0;
    repeat (3) begin
      step;
      vectors++;
      if ({mem_req, mem_we, busy, i_ready, d_ready} !== 5'b0) begin
        errors++; $display("FAIL reset_ctrl got %b required 00000", {mem_req, mem_we, busy, i_ready, d_ready});
      end
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_data got addr %h wdata %h required 0", mem_addr, mem_wdata);
    end
    vectors++;
    if (i_grants !== 2'd0 || d_grants !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got i %0d d %0d required 0 0", i_grants, d_grants);
    end
    reset = 1;
    step;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin
      errors++; $display("FAIL reset_first_grant got req %b addr %h required 1 00002000", mem_req, mem_addr);
    end
    vectors++;
    if (d_grants !== 2'd1 || i_grants !== 2'd0) begin
      errors++; $display("FAIL reset_first_cnt got i %0d d %0d required 0 1", i_grants, d_grants);
    end
    mem_ack = 1; mem_rdata = {4{32'h11223344}};
    step;
    vectors++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== {4{32'h11223344}}) begin
      errors++; $display("FAIL reset_first_ready got d %b i %b data %h", d_ready, i_ready, d_rdata);
    end
    mem_ack = 0; i_req = 0; d_req = 0;
    step;
  endtask

  task automatic test_icache_fill;
    do_reset;
    i_req = 1; i_addr = 32'h100;
    for (int k = 1; k <= 3; k++) begin
      step;
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
        errors++; $display("FAIL ifill_busy_%0d got req %b we %b addr %h ir %b dr %b", k, mem_req, mem_we, mem_addr, i_ready, d_ready);
      end
    end
    mem_ack = 1; mem_rdata = {4{32'hDEADBEEF}};
    step;
    vectors++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ifill_resp got ir %b dr %b req %b busy %b required 1 0 0 1", i_ready, d_ready, mem_req, busy);
    end
    vectors++;
    if (i_rdata !== {4{32'hDEADBEEF}}) begin
      errors++; $display("FAIL ifill_data got %h required %h", i_rdata, {4{32'hDEADBEEF}});
    end
    mem_ack = 0; i_req = 0;
    step;
    vectors++;
    if (i_ready !== 1'b0 || busy !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL ifill_idle got ir %b busy %b dr %b required 0 0 0", i_ready, busy, d_ready);
    end
  endtask

  task automatic test_writeback;
    do_reset;
    d_req = 1; d_we = 1; d_addr = 32'h2040; d_wdata = {16{8'hA5}};
    for (int k = 1; k <= 3; k++) begin
      step;
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2040 || mem_wdata !== {16{8'hA5}}) begin
        errors++; $display("FAIL wb_busy_%0d got req %b we %b addr %h wdata %h", k, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    mem_ack = 1; mem_rdata = '0;
    step;
    vectors++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL wb_resp got dr %b ir %b we %b required 1 0 0", d_ready, i_ready, mem_we);
    end
    mem_ack = 0; d_req = 0; d_we = 0;
    step;
    vectors++;
    if (d_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wb_idle got dr %b busy %b required 0 0", d_ready, busy);
    end
  endtask

  task automatic test_contention;
    logic exp_d;
    int   n;
    do_reset;
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h1000; d_addr = 32'h8000;
    exp_d = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      while (mem_req !== 1'b1 && n < 8) begin
        step; n++;
      end
      vectors++;
      if (mem_req !== 1'b1) begin
        errors++; $display("FAIL contend_timeout_%0d got no mem_req within 8 cycles", t);
        i_req = 0; d_req = 0;
        return;
      end
      vectors++;
      if (mem_addr !== (exp_d ? 32'h8000 : 32'h1000)) begin
        errors++; $display("FAIL contend_order_%0d got addr %h required %h", t, mem_addr, exp_d ? 32'h8000 : 32'h1000);
      end
      step; step;
      mem_ack = 1; mem_rdata = {4{t[31:0] + 32'hC0DE0000}};
      step;
      vectors++;
      if (d_ready !== exp_d || i_ready !== !exp_d || i_rdata !== {4{t[31:0] + 32'hC0DE0000}}) begin
        errors++; $display("FAIL contend_ready_%0d got dr %b ir %b data %h required dr %b", t, d_ready, i_ready, i_rdata, exp_d);
      end
      mem_ack = 0;
      exp_d = !exp_d;
    end
    vectors++;
    if (i_grants !== 2'd3 || d_grants !== 2'd3) begin
      errors++; $display("FAIL contend_cnt got i %0d d %0d required 3 3", i_grants, d_grants);
    end
    i_req = 0; d_req = 0;
    step; step;
  endtask

  task automatic test_reset_mid_busy;
    do_reset;
    i_req = 1; i_addr = 32'h300;
    step; step;
    #2 reset = 0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || i_grants !== 2'd0) begin
      errors++; $display("FAIL midrst_async got req %b busy %b icnt %0d required 0 0 0", mem_req, busy, i_grants);
    end
    mem_ack = 1;
    step;
    vectors++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL midrst_noready got ir %b dr %b req %b required 0 0 0", i_ready, d_ready, mem_req);
    end
    i_req = 0; mem_ack = 0;
    step;
    reset = 1;
    d_req = 1; d_we = 0; d_addr = 32'h440;
    step;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h440 || d_grants !== 2'd1 || i_grants !== 2'd0) begin
      errors++; $display("FAIL midrst_regrant got req %b addr %h d %0d i %0d required 1 00000440 1 0", mem_req, mem_addr, d_grants, i_grants);
    end
    mem_ack = 1; mem_rdata = {4{32'h5A5A0440}};
    step;
    vectors++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== {4{32'h5A5A0440}}) begin
      errors++; $display("FAIL midrst_ready got dr %b ir %b data %h", d_ready, i_ready, d_rdata);
    end
    mem_ack = 0; d_req = 0;
    step;
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt;
    do_reset;
    for (int k = 1; k <= 5; k++) begin
      i_req = 1; i_addr = 32'(k * 16);
      step;
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      vectors++;
      if (i_grants !== exp_cnt || mem_req !== 1'b1) begin
        errors++; $display("FAIL sat_cnt_%0d got %0d req %b required %0d 1", k, i_grants, mem_req, exp_cnt);
      end
      mem_ack = 1; mem_rdata = {4{32'hF00D0000 + 32'(k)}};
      step;
      vectors++;
      if (i_ready !== 1'b1) begin
        errors++; $display("FAIL sat_ready_%0d got %b required 1", k, i_ready);
      end
      mem_ack = 0; i_req = 0;
      step;
    end
    mem_ack = 1; mem_rdata = {LINE_W{1'b1}};
    repeat (2) begin
      step;
      vectors++;
      if ({busy, mem_req, i_ready, d_ready} !== 4'b0 || i_rdata !== {4{32'hF00D0005}}) begin
        errors++; $display("FAIL spurious_ack got ctrl %b data %h required 0000 %h", {busy, mem_req, i_ready, d_ready}, i_rdata, {4{32'hF00D0005}});
      end
    end
    mem_ack = 0;
  endtask

  initial begin
    test_reset;
    test_icache_fill;
    test_writeback;
    test_contention;
    test_reset_mid_busy;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
